// File: rtl/ex_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_pkg
//   Shared definitions for the EX->MEM pipeline boundary of the RV32I core:
//   default widths, the control-class encoding used by the branch target
//   unit, the link offset for jal/jalr, and a helper that folds the three
//   one-hot control-class inputs into that encoding.
// ---------------------------------------------------------------------------
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int CNT_W_DEF   = 32;
    localparam int LINK_OFFSET = 4;

    // Control class of the instruction sitting in EX.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JAL    = 2'd2,
        CLS_JALR   = 2'd3
    } ctrl_class_e;

    // The decode stage guarantees one-hot or all-zero; the priority order
    // below only matters if that guarantee is ever broken.
    function automatic ctrl_class_e decode_class(input logic is_branch,
                                                 input logic is_jal,
                                                 input logic is_jalr);
        ctrl_class_e cls;
        cls = CLS_NONE;
        if (is_jalr) begin
            cls = CLS_JALR;
        end else if (is_jal) begin
            cls = CLS_JAL;
        end else if (is_branch) begin
            cls = CLS_BRANCH;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ex_mem_stage_branch_target_unit.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_branch_target_unit
//   Purely combinational branch/jump resolution for the instruction in EX.
//
//   Ports:
//     pc, imm, alu_result  in   EX PC, sign-extended immediate, ALU result
//     bcond                in   ALU branch condition
//     cls                  in   control class (none/branch/jal/jalr)
//     taken                out  control transfer happens
//     target               out  transfer target (mod 2^DATA_W)
//     misalign             out  taken and target[1] set
// ---------------------------------------------------------------------------
module ex_mem_stage_branch_target_unit
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              bcond,
    input  ctrl_class_e       cls,
    output logic              taken,
    output logic [DATA_W-1:0] target,
    output logic              misalign
);

    always_comb begin
        taken  = 1'b0;
        // pc+imm covers both conditional branches and jal; the adder wraps.
        target = pc + imm;
        case (cls)
            CLS_BRANCH: taken = bcond;
            CLS_JAL:    taken = 1'b1;
            CLS_JALR: begin
                taken  = 1'b1;
                target = alu_result & ~DATA_W'(1);
            end
            default:    taken = 1'b0;
        endcase
        // Only bit 1 matters: bit 0 is always clear for legal targets.
        misalign = taken & target[1];
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   Registered EX->MEM boundary. Resolves branches/jumps into a one-cycle PC
//   redirect (or a misalignment trap pulse), drops the wrong-path instruction
//   that is in EX during the redirect cycle, holds the MEM payload while the
//   memory stage stalls, and counts branches / taken branches.
//
//   Ports:
//     clk, reset                 clock, async active-low reset
//     ex_valid / ex_ready        EX-side handshake
//     ex_pc, ex_imm, ex_alu_result, ex_alu_bcond   datapath inputs
//     ex_is_branch/_jal/_jalr    control class (one-hot or zero)
//     ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
//     ex_mem_to_reg              fields forwarded to MEM
//     mem_valid / mem_ready      MEM-side handshake
//     mem_*                      registered payload
//     redirect_valid/_pc         one-cycle PC redirect
//     misalign_trap              one-cycle pulse, taken target with bit1 set
//     branch_count, taken_count  event counters (wrap)
//
//   Handshake: a transfer happens on a clock edge where valid and ready are
//   both 1. mem_valid never drops and the mem_* payload never changes while
//   mem_valid=1 and mem_ready=0. ex_ready may depend combinationally on
//   mem_ready. In the cycle redirect_valid=1 the EX instruction is consumed
//   (ex_ready=1) but discarded, because it is on the wrong path.
// ---------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // EX side
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_imm,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_alu_bcond,
    input  logic              ex_is_branch,
    input  logic              ex_is_jal,
    input  logic              ex_is_jalr,
    input  logic [DATA_W-1:0] ex_rs2_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    // MEM side
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_rs2_data,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    // Control transfer
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              misalign_trap,
    // Event counters
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    ctrl_class_e       ex_cls;
    logic              taken;
    logic [DATA_W-1:0] target;
    logic              misalign;
    logic              accept;

    logic              mem_valid_q,      mem_valid_d;
    logic [DATA_W-1:0] mem_result_q,     mem_result_d;
    logic [DATA_W-1:0] mem_rs2_data_q,   mem_rs2_data_d;
    logic [4:0]        mem_rd_q,         mem_rd_d;
    logic              mem_reg_write_q,  mem_reg_write_d;
    logic              mem_mem_read_q,   mem_mem_read_d;
    logic              mem_mem_write_q,  mem_mem_write_d;
    logic              mem_mem_to_reg_q, mem_mem_to_reg_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0] redirect_pc_q,    redirect_pc_d;
    logic              misalign_trap_q,  misalign_trap_d;
    logic [CNT_W-1:0]  branch_count_q,   branch_count_d;
    logic [CNT_W-1:0]  taken_count_q,    taken_count_d;

    assign ex_cls = decode_class(ex_is_branch, ex_is_jal, ex_is_jalr);

    ex_mem_stage_branch_target_unit #(
        .DATA_W (DATA_W)
    ) u_branch_target_unit (
        .pc         (ex_pc),
        .imm        (ex_imm),
        .alu_result (ex_alu_result),
        .bcond      (ex_alu_bcond),
        .cls        (ex_cls),
        .taken      (taken),
        .target     (target),
        .misalign   (misalign)
    );

    always_comb begin
        // Gated by reset so that every output reads 0 while reset is held.
        ex_ready = reset & (~mem_valid_q | mem_ready | redirect_valid_q);
        // During a redirect cycle the EX instruction is consumed but not
        // loaded (squash): no payload, no counting, no further redirect.
        accept   = ex_valid & ex_ready & ~redirect_valid_q;

        mem_valid_d      = mem_valid_q;
        mem_result_d     = mem_result_q;
        mem_rs2_data_d   = mem_rs2_data_q;
        mem_rd_d         = mem_rd_q;
        mem_reg_write_d  = mem_reg_write_q;
        mem_mem_read_d   = mem_mem_read_q;
        mem_mem_write_d  = mem_mem_write_q;
        mem_mem_to_reg_d = mem_mem_to_reg_q;
        redirect_pc_d    = redirect_pc_q;
        branch_count_d   = branch_count_q;
        taken_count_d    = taken_count_q;

        if (accept) begin
            mem_valid_d      = 1'b1;
            mem_result_d     = (ex_is_jal | ex_is_jalr)
                               ? ex_pc + DATA_W'(LINK_OFFSET)
                               : ex_alu_result;
            mem_rs2_data_d   = ex_rs2_data;
            mem_rd_d         = ex_rd;
            // A misaligned jump must not write its link register.
            mem_reg_write_d  = ex_reg_write & ~misalign;
            mem_mem_read_d   = ex_mem_read;
            mem_mem_write_d  = ex_mem_write;
            mem_mem_to_reg_d = ex_mem_to_reg;
            redirect_pc_d    = target;
            if (ex_is_branch) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
            if (ex_is_branch & ex_alu_bcond) begin
                taken_count_d = taken_count_q + CNT_W'(1);
            end
        end else if (mem_ready) begin
            // Payload drained into MEM; fields hold but are no longer valid.
            mem_valid_d = 1'b0;
        end

        // Pulses are tied to accept, so a branch stalled in MEM cannot
        // re-assert them.
        redirect_valid_d = accept & taken & ~misalign;
        misalign_trap_d  = accept & misalign;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid_q      <= 1'b0;
            mem_result_q     <= '0;
            mem_rs2_data_q   <= '0;
            mem_rd_q         <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_trap_q  <= 1'b0;
            branch_count_q   <= '0;
            taken_count_q    <= '0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_result_q     <= mem_result_d;
            mem_rs2_data_q   <= mem_rs2_data_d;
            mem_rd_q         <= mem_rd_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_trap_q  <= misalign_trap_d;
            branch_count_q   <= branch_count_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_result     = mem_result_q;
    assign mem_rs2_data   = mem_rs2_data_q;
    assign mem_rd         = mem_rd_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_read   = mem_mem_read_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign misalign_trap  = misalign_trap_q;
    assign branch_count   = branch_count_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Directed + random stimulus for ex_mem_stage. The driver pushes the MEM
//   payload each accepted instruction must produce into exp_q and keeps a
//   transaction-level picture of the stage (slot occupied, redirect pending,
//   counters); a separate monitor compares the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_pc, ex_imm, ex_alu_result, ex_rs2_data;
    logic              ex_alu_bcond, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic              mem_valid, mem_ready;
    logic [DATA_W-1:0] mem_result, mem_rs2_data;
    logic [4:0]        mem_rd;
    logic              mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              misalign_trap;
    logic [CNT_W-1:0]  branch_count, taken_count;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        bcond;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
    } txn_t;

    // Transaction-level view of the stage after a clock edge.
    typedef struct packed {
        logic        occ;
        logic        redir;
        logic        mis;
        logic [31:0] redir_pc;
        logic [31:0] bcnt;
        logic [31:0] tcnt;
    } mdl_t;

    mdl_t        cur = '0;
    mdl_t        nxt = '0;
    logic [72:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          in_reset = 1'b1;
    bit          run_mon  = 1'b0;

    ex_mem_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_alu_result  (ex_alu_result),
        .ex_alu_bcond   (ex_alu_bcond),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_rs2_data    (ex_rs2_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_result     (mem_result),
        .mem_rs2_data   (mem_rs2_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_trap  (misalign_trap),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] alu, input logic bcond, input logic br,
                                input logic jal, input logic jalr);
        txn_t t;
        t = '0;
        t.valid = v; t.pc = pc; t.imm = imm; t.alu = alu; t.bcond = bcond;
        t.is_branch = br; t.is_jal = jal; t.is_jalr = jalr;
        t.rs2 = $urandom; t.rd = 5'($urandom_range(1, 31));
        t.rw = (jal || jalr) ? 1'b1 : ~br;
        t.mr = 1'b0; t.mw = 1'b0; t.mtr = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   cls;
        cls = $urandom_range(0, 3);
        t = mk(($urandom_range(0, 4) != 0), $urandom & 32'hFFFF_FFFC, 32'h0,
               $urandom, 1'($urandom_range(0, 1)), cls == 1, cls == 2, cls == 3);
        // Mostly aligned targets, sometimes bit1 set to provoke misalign.
        t.imm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom & 32'hFFFF_FFFC);
        if (cls == 3 && $urandom_range(0, 3) != 0) t.alu = t.alu & 32'hFFFF_FFFC;
        if (cls == 0) begin
            t.mr = 1'($urandom_range(0, 1));
            t.mw = ~t.mr & 1'($urandom_range(0, 1));
            t.mtr = t.mr;
            t.rw = ~t.mw;
        end
        return t;
    endfunction

    task automatic set_inputs(input txn_t t, input logic rdy);
        ex_valid = t.valid; ex_pc = t.pc; ex_imm = t.imm; ex_alu_result = t.alu;
        ex_alu_bcond = t.bcond; ex_is_branch = t.is_branch; ex_is_jal = t.is_jal;
        ex_is_jalr = t.is_jalr; ex_rs2_data = t.rs2; ex_rd = t.rd;
        ex_reg_write = t.rw; ex_mem_read = t.mr; ex_mem_write = t.mw; ex_mem_to_reg = t.mtr;
        mem_ready = rdy;
    endtask

    // ---------------- driver + reference model ----------------
    // Applies one cycle of stimulus just after a rising edge and predicts
    // what the stage looks like after the next edge.
    task automatic drive_cycle(input txn_t t, input logic rdy);
        logic        taken, mis, acc;
        logic [31:0] tgt, res;
        @(posedge clk);
        #1;
        cur = nxt;
        set_inputs(t, rdy);
        taken = (t.is_branch && t.bcond) || t.is_jal || t.is_jalr;
        tgt   = t.is_jalr ? {t.alu[31:1], 1'b0} : t.pc + t.imm;
        mis   = taken && tgt[1];
        // A pending redirect means EX holds a wrong-path instruction: drop it.
        // Otherwise EX moves on when the MEM slot is free or being drained.
        if (cur.redir) acc = 1'b0;
        else           acc = t.valid && (!cur.occ || rdy);
        nxt = cur;
        nxt.redir = acc && taken && !mis;
        nxt.mis   = acc && mis;
        if (acc) begin
            nxt.occ      = 1'b1;
            nxt.redir_pc = tgt;
            res = (t.is_jal || t.is_jalr) ? t.pc + 32'd4 : t.alu;
            exp_q.push_back({res, t.rs2, t.rd, t.rw && !mis, t.mr, t.mw, t.mtr});
            if (t.is_branch) nxt.bcnt = cur.bcnt + 1;
            if (t.is_branch && t.bcond) nxt.tcnt = cur.tcnt + 1;
        end else if (rdy) begin
            nxt.occ = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(mk(1'b0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_ready"},      64'(ex_ready), 64'd0);
        check({tag, "_mem_valid"},     64'(mem_valid), 64'd0);
        check({tag, "_mem_result"},    64'(mem_result), 64'd0);
        check({tag, "_mem_rs2"},       64'(mem_rs2_data), 64'd0);
        check({tag, "_mem_ctrl"},      64'({mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}), 64'd0);
        check({tag, "_redirect"},      64'({redirect_valid, misalign_trap}), 64'd0);
        check({tag, "_redirect_pc"},   64'(redirect_pc), 64'd0);
        check({tag, "_counters"},      {branch_count, taken_count}, 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        logic [72:0] e;
        if (run_mon && !in_reset) begin
            check("ex_ready",       64'(ex_ready), 64'(!cur.occ || mem_ready || cur.redir));
            check("mem_valid",      64'(mem_valid), 64'(cur.occ));
            check("redirect_valid", 64'(redirect_valid), 64'(cur.redir));
            check("misalign_trap",  64'(misalign_trap), 64'(cur.mis));
            if (cur.redir) check("redirect_pc", 64'(redirect_pc), 64'(cur.redir_pc));
            check("branch_count",   64'(branch_count), 64'(cur.bcnt));
            check("taken_count",    64'(taken_count), 64'(cur.tcnt));
            if (cur.occ) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q[0];
                    check("mem_result", 64'(mem_result), 64'(e[72:41]));
                    check("mem_rs2",    64'(mem_rs2_data), 64'(e[40:9]));
                    check("mem_ctrl",   64'({mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}), 64'(e[8:0]));
                    if (mem_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        set_inputs(mk(1'b0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        #2;
        reset    = 1'b1;
        in_reset = 1'b0;
        run_mon  = 1'b1;

        // plain add
        drive_cycle(mk(1'b1, 32'h0, 32'h0, 32'h10, 1'b0, 0, 0, 0), 1'b1);
        idle(2);
        // beq taken, followed by a wrong-path instruction that must drop
        drive_cycle(mk(1'b1, 32'h100, 32'h20, 32'h0, 1'b1, 1, 0, 0), 1'b1);
        drive_cycle(mk(1'b1, 32'h104, 32'h0, 32'h55, 1'b0, 0, 0, 0), 1'b1);
        idle(2);
        // jalr: target 0x204, link 0x44
        drive_cycle(mk(1'b1, 32'h40, 32'h0, 32'h205, 1'b0, 0, 0, 1), 1'b1);
        idle(2);
        // jal with misaligned target 0x202
        drive_cycle(mk(1'b1, 32'h100, 32'h102, 32'h0, 1'b0, 0, 1, 0), 1'b1);
        drive_cycle(mk(1'b1, 32'h104, 32'h0, 32'h77, 1'b0, 0, 0, 0), 1'b1);
        idle(2);
        // taken branch then a 3-cycle MEM stall
        drive_cycle(mk(1'b1, 32'h200, 32'h40, 32'h0, 1'b1, 1, 0, 0), 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(mk(1'b1, 32'h204, 32'h0, 32'h99, 1'b0, 0, 0, 0), 1'b0);
        idle(2);
        // PC wrap-around target
        drive_cycle(mk(1'b1, 32'hFFFF_FFF0, 32'h14, 32'h0, 1'b1, 1, 0, 0), 1'b1);
        idle(2);

        // reset asserted between edges in the middle of a stall
        drive_cycle(mk(1'b1, 32'h300, 32'h8, 32'h0, 1'b1, 1, 0, 0), 1'b1);
        drive_cycle(mk(1'b1, 32'h304, 32'h0, 32'h1, 1'b0, 0, 0, 0), 1'b0);
        drive_cycle(mk(1'b1, 32'h304, 32'h0, 32'h1, 1'b0, 0, 0, 0), 1'b0);
        #3;
        in_reset = 1'b1;
        reset    = 1'b0;
        #1;
        check_all_zero("midstall_reset");
        set_inputs(mk(1'b0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        cur = '0;
        nxt = '0;
        exp_q.delete();
        @(posedge clk);
        #3;
        reset    = 1'b1;
        in_reset = 1'b0;
        // not-taken branch after release
        drive_cycle(mk(1'b1, 32'h400, 32'h10, 32'h0, 1'b0, 1, 0, 0), 1'b1);
        drive_cycle(mk(1'b0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        check("post_reset_branch_count", 64'(branch_count), 64'd1);
        check("post_reset_taken_count",  64'(taken_count), 64'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(rand_txn(), ($urandom_range(0, 9) < 7));
        end
        idle(6);
        @(negedge clk);
        #1;
        run_mon = 1'b0;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Registered EX→MEM boundary of the pipelined RV32I core; consumes the ALU's alu_result/alu_bcond plus EX-stage control.
- Resolves branches and jumps into a one-cycle PC redirect, squashes the wrong-path instruction in EX, and holds its payload under a valid/ready stall from the memory stage.
- Keeps branch/taken event counters.

Parameters:
- DATA_W, 32, datapath and PC width.
- CNT_W, 32, width of the event counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- ex_valid  input  1  EX holds a valid instruction
- ex_ready  output  1  stage can accept this cycle
- ex_pc  input  DATA_W  PC of the EX instruction
- ex_imm  input  DATA_W  sign-extended immediate
- ex_alu_result  input  DATA_W  ALU result
- ex_alu_bcond  input  1  ALU branch condition
- ex_is_branch / ex_is_jal / ex_is_jalr  input  1 each  control class, one-hot or all zero
- ex_rs2_data  input  DATA_W  store data
- ex_rd  input  5  destination register
- ex_reg_write / ex_mem_read / ex_mem_write / ex_mem_to_reg  input  1 each  control
- mem_valid  output  1  payload valid to MEM
- mem_ready  input  1  MEM accepts (0 = data-memory stall)
- mem_result  output  DATA_W  address/ALU value or link value
- mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  registered copies
- redirect_valid  output  1  one-cycle PC redirect pulse
- redirect_pc  output  DATA_W  redirect target
- misalign_trap  output  1  one-cycle pulse: taken target has bit1 set
- branch_count, taken_count  output  CNT_W  event counters

Behaviour:
- Reset (async, reset=0): every output 0, counters 0; release takes effect on the next clk edge.
- ex_ready = !mem_valid | mem_ready | redirect_valid (combinational).
- accept = ex_valid & ex_ready & !redirect_valid.
- squash = ex_valid & redirect_valid: EX instruction consumed and dropped; no load, no counting, no redirect.
- On accept, load all mem_* fields and set mem_valid=1.
- mem_result = ex_pc+4 if jal/jalr, else ex_alu_result.
- If no accept and mem_ready=1: mem_valid←0 (payload fields hold).
- If no accept and mem_ready=0: full hold of valid and payload.
- taken = branch&bcond | jal | jalr.
- target = (ex_alu_result & ~1) for jalr, else ex_pc+ex_imm. Modulo 2^DATA_W, wrap silently.
- redirect_valid registered: 1 for exactly the cycle after an accept with taken=1 and target[1]=0, else 0. Never re-asserts while the branch is stalled in MEM.
- redirect_pc is loaded with target on every accept; it is meaningful only while redirect_valid=1.
- If taken and target[1]=1: misalign_trap pulses instead of redirect_valid; the instruction still enters MEM with reg_write forced 0.
- Counters, on accept only: branch_count +1 if ex_is_branch; taken_count +1 if branch&bcond. Both wrap at 2^CNT_W.
- Back-to-back taken branches are impossible by construction: the second is squashed by the first's redirect.
- reset asserted mid-stall: instruction lost, outputs 0 immediately.
- Latency EX→MEM: 1 cycle; EX→redirect: 1 cycle.

Decomposition:
- Shared package: DATA_W default, control-class encodings, link offset constant 4.
- Natural sub-module: branch_target_unit (combinational taken/target/misalign computation), instantiated once.
- Counters and the pipeline register stay in the top.

Test Plan:
- Plain add, ex_alu_result=0x10, mem_ready=1 → next cycle mem_valid=1, mem_result=0x10, redirect_valid=0.
- beq, bcond=1, pc=0x100, imm=0x20 → next cycle redirect_valid=1, redirect_pc=0x120, taken_count=1. Instruction presented in EX that cycle is dropped: mem_valid falls the following cycle.
- jalr, alu_result=0x205, pc=0x40 → redirect_pc=0x204, mem_result=0x44.
- jal, pc=0x100, imm=0x102 (target 0x202, bit1 set) → misalign_trap=1 for one cycle, redirect_valid=0, mem_reg_write=0.
- Taken branch accepted, then mem_ready=0 for 3 cycles → ex_ready=0 for cycles 2–3 (cycle 1 is the squash cycle, ex_ready=1); mem payload stable; redirect_valid high on cycle 1 only.
- reset driven low mid-stall, async and between clock edges → all outputs 0 immediately. After release, a not-taken branch → branch_count=1, taken_count=0.
